// File: rtl/rounding_pipe.sv
// Two-stage IEEE-754 mantissa rounding pipeline with valid/ready backpressure and flush.
// Optional sideband tag travels with each beat when ROUNDING_PIPE_TAG_EN is defined.
module rounding_pipe #(
  parameter int WIDTH     = 24,
  parameter int EXP_WIDTH = 8
`ifdef ROUNDING_PIPE_TAG_EN
  , parameter int TAG_WIDTH = 8
`endif
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_mant,
  input  logic [EXP_WIDTH-1:0] in_exp,
  input  logic                 in_sign,
  input  logic                 in_round,
  input  logic                 in_sticky,
  input  logic [2:0]           in_rm,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_mant,
  output logic [EXP_WIDTH-1:0] out_exp,
  output logic                 out_sign,
  output logic                 out_inexact,
  output logic                 out_overflow,
  output logic                 out_rm_err
`ifdef ROUNDING_PIPE_TAG_EN
  ,
  input  logic [TAG_WIDTH-1:0] in_tag,
  output logic [TAG_WIDTH-1:0] out_tag
`endif
);

  typedef enum logic [2:0] {
    RM_RNE = 3'd0,
    RM_RTZ = 3'd1,
    RM_RDN = 3'd2,
    RM_RUP = 3'd3,
    RM_RMM = 3'd4
  } rm_e;

  logic                 s1_valid;
  logic [WIDTH-1:0]     s1_mant;
  logic [EXP_WIDTH-1:0] s1_exp;
  logic                 s1_sign;
  logic                 s1_up;
  logic                 s1_inexact;
  logic                 s1_rm_err;
  logic                 s2_valid;

  logic                 s1_adv;
  logic                 s2_adv;
  logic                 in_inexact;
  logic                 in_up;
  logic                 in_err;

  logic [WIDTH:0]       sum;
  logic                 carry;
  logic                 exp_max;
  logic                 exp_near_max;
  logic [WIDTH-1:0]     rnd_mant;
  logic [EXP_WIDTH-1:0] rnd_exp;
  logic                 rnd_ovf;

  // Ready ripples back from the output so a full pipe still streams at one beat per cycle.
  always_comb begin
    s2_adv   = !s2_valid || out_ready;
    s1_adv   = !s1_valid || s2_adv;
    in_ready = s1_adv && !flush;
  end

  always_comb begin
    in_inexact = in_round | in_sticky;
    in_up      = 1'b0;
    in_err     = 1'b0;
    case (in_rm)
      RM_RNE:  in_up = in_round & (in_sticky | in_mant[0]);
      RM_RTZ:  in_up = 1'b0;
      RM_RDN:  in_up = in_inexact & in_sign;
      RM_RUP:  in_up = in_inexact & ~in_sign;
      RM_RMM:  in_up = in_round;
      default: in_err = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid   <= 1'b0;
      s1_mant    <= '0;
      s1_exp     <= '0;
      s1_sign    <= 1'b0;
      s1_up      <= 1'b0;
      s1_inexact <= 1'b0;
      s1_rm_err  <= 1'b0;
    end else begin
      if (flush) begin
        s1_valid <= 1'b0;
      end else if (s1_adv) begin
        s1_valid <= in_valid;
      end
      if (in_valid && in_ready) begin
        s1_mant    <= in_mant;
        s1_exp     <= in_exp;
        s1_sign    <= in_sign;
        s1_up      <= in_up;
        s1_inexact <= in_inexact;
        s1_rm_err  <= in_err;
      end
    end
  end

  // A carry out of the mantissa renormalises to 1.000...; an all-ones exponent is never wrapped.
  always_comb begin
    sum          = {1'b0, s1_mant} + {{WIDTH{1'b0}}, s1_up};
    carry        = sum[WIDTH];
    exp_max      = &s1_exp;
    exp_near_max = (s1_exp == {{(EXP_WIDTH-1){1'b1}}, 1'b0});
    rnd_mant     = sum[WIDTH-1:0];
    rnd_exp      = s1_exp;
    rnd_ovf      = 1'b0;
    if (carry) begin
      rnd_mant = {1'b1, {(WIDTH-1){1'b0}}};
      rnd_ovf  = exp_near_max;
      if (!exp_max) begin
        rnd_exp = s1_exp + EXP_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid     <= 1'b0;
      out_mant     <= '0;
      out_exp      <= '0;
      out_sign     <= 1'b0;
      out_inexact  <= 1'b0;
      out_overflow <= 1'b0;
      out_rm_err   <= 1'b0;
    end else begin
      if (flush) begin
        s2_valid <= 1'b0;
      end else if (s2_adv) begin
        s2_valid <= s1_valid;
      end
      if (s2_adv && s1_valid && !flush) begin
        out_mant     <= rnd_mant;
        out_exp      <= rnd_exp;
        out_sign     <= s1_sign;
        out_inexact  <= s1_inexact;
        out_overflow <= rnd_ovf;
        out_rm_err   <= s1_rm_err;
      end
    end
  end

  assign out_valid = s2_valid;

`ifdef ROUNDING_PIPE_TAG_EN
  logic [TAG_WIDTH-1:0] s1_tag;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_tag  <= '0;
      out_tag <= '0;
    end else begin
      if (in_valid && in_ready) begin
        s1_tag <= in_tag;
      end
      if (s2_adv && s1_valid && !flush) begin
        out_tag <= s1_tag;
      end
    end
  end
`else
  // Tag-less build: no sideband storage.
`endif

endmodule

// File: tb/tb_rounding_pipe.sv
// Self-checking bench for rounding_pipe: vector table, scoreboard queue, stall/flush/reset sequences.
// Tag checks are active when ROUNDING_PIPE_TAG_EN is defined.
module tb_rounding_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [23:0] in_mant;
  logic [7:0]  in_exp;
  logic        in_sign;
  logic        in_round;
  logic        in_sticky;
  logic [2:0]  in_rm;
  logic        out_valid;
  logic        out_ready;
  logic [23:0] out_mant;
  logic [7:0]  out_exp;
  logic        out_sign;
  logic        out_inexact;
  logic        out_overflow;
  logic        out_rm_err;
`ifdef ROUNDING_PIPE_TAG_EN
  logic [7:0]  in_tag;
  logic [7:0]  out_tag;
`endif

  typedef struct {
    logic [23:0] mant;
    logic [7:0]  exp;
    logic        sign;
    logic        inexact;
    logic        overflow;
    logic        rm_err;
    logic [7:0]  tag;
  } beat_t;

  typedef struct {
    logic [23:0] mant;
    logic [7:0]  exp;
    logic        sign;
    logic        round;
    logic        sticky;
    logic [2:0]  rm;
    logic [23:0] x_mant;
    logic [7:0]  x_exp;
    logic        x_inexact;
    logic        x_overflow;
    logic        x_rm_err;
  } vec_t;

  localparam int NVEC = 13;
  vec_t  vecs [NVEC];
  beat_t sb_q[$];
  beat_t cur;
  beat_t held;
  bit    prev_stall;
  bit    tog_run;
  int    tests_run;
  int    tests_failed;
  int    pop_count;

  rounding_pipe #(.WIDTH(24), .EXP_WIDTH(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_mant      (in_mant),
    .in_exp       (in_exp),
    .in_sign      (in_sign),
    .in_round     (in_round),
    .in_sticky    (in_sticky),
    .in_rm        (in_rm),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_mant     (out_mant),
    .out_exp      (out_exp),
    .out_sign     (out_sign),
    .out_inexact  (out_inexact),
    .out_overflow (out_overflow),
    .out_rm_err   (out_rm_err)
`ifdef ROUNDING_PIPE_TAG_EN
    ,
    .in_tag       (in_tag),
    .out_tag      (out_tag)
`endif
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    tests_run++;
    if (act !== req) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Independent reference for randomly generated beats.
  function automatic beat_t ref_model(input logic [23:0] m, input logic [7:0] x, input logic s,
                                      input logic r, input logic st, input logic [2:0] rm,
                                      input logic [7:0] tag);
    beat_t       b;
    logic        up;
    logic [24:0] total;
    case (rm)
      3'd0:    up = r && (st || m[0]);
      3'd2:    up = (r || st) && s;
      3'd3:    up = (r || st) && !s;
      3'd4:    up = r;
      default: up = 1'b0;
    endcase
    total      = {1'b0, m} + {24'd0, up};
    b.sign     = s;
    b.inexact  = r || st;
    b.rm_err   = (rm > 3'd4);
    b.tag      = tag;
    b.overflow = 1'b0;
    if (total == 25'h1000000) begin
      b.mant     = 24'h800000;
      b.exp      = (x == 8'hFF) ? x : x + 8'd1;
      b.overflow = (x == 8'hFE);
    end else begin
      b.mant = total[23:0];
      b.exp  = x;
    end
    return b;
  endfunction

  task automatic applyStimulus(input logic [23:0] m, input logic [7:0] x, input logic s,
                               input logic r, input logic st, input logic [2:0] rm,
                               input logic [7:0] tag, input beat_t e);
    bit acc = 1'b0;
    in_mant   = m;
    in_exp    = x;
    in_sign   = s;
    in_round  = r;
    in_sticky = st;
    in_rm     = rm;
`ifdef ROUNDING_PIPE_TAG_EN
    in_tag    = tag;
`endif
    cur       = e;
    in_valid  = 1'b1;
    for (int n = 0; n < 100 && !acc; n++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!acc) checkOutput("accept_timeout", 32'(acc), 32'd1);
  endtask

  task automatic waitDrain();
    for (int n = 0; n < 300 && sb_q.size() != 0; n++) begin
      @(posedge clk);
      #1;
    end
    checkOutput("drain_left", 32'(sb_q.size()), 32'd0);
  endtask

  // Scoreboard: pop on output handshake, push on input handshake, sampled at negedge.
  always @(negedge clk) begin
    beat_t e;
    if (!rst_n) begin
      sb_q.delete();
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && out_valid) begin
        checkOutput("stall_mant", 32'(out_mant), 32'(held.mant));
        checkOutput("stall_exp", 32'(out_exp), 32'(held.exp));
        checkOutput("stall_flags", {29'd0, out_inexact, out_overflow, out_rm_err},
                    {29'd0, held.inexact, held.overflow, held.rm_err});
      end
      if (sb_q.size() == 2 && !out_ready) checkOutput("full_in_ready", 32'(in_ready), 32'd0);
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          tests_run++;
          tests_failed++;
          $display("[TB] FAIL unexpected_beat: got mant %h exp %h, expected no output", out_mant, out_exp);
        end else begin
          e = sb_q.pop_front();
          pop_count++;
          checkOutput("out_mant", 32'(out_mant), 32'(e.mant));
          checkOutput("out_exp", 32'(out_exp), 32'(e.exp));
          checkOutput("out_sign", 32'(out_sign), 32'(e.sign));
          checkOutput("out_inexact", 32'(out_inexact), 32'(e.inexact));
          checkOutput("out_overflow", 32'(out_overflow), 32'(e.overflow));
          checkOutput("out_rm_err", 32'(out_rm_err), 32'(e.rm_err));
`ifdef ROUNDING_PIPE_TAG_EN
          checkOutput("out_tag", 32'(out_tag), 32'(e.tag));
`endif
        end
      end
      if (flush) sb_q.delete();
      else if (in_valid && in_ready) sb_q.push_back(cur);
      prev_stall   = out_valid && !out_ready && !flush;
      held.mant    = out_mant;
      held.exp     = out_exp;
      held.inexact = out_inexact;
      held.overflow = out_overflow;
      held.rm_err  = out_rm_err;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    beat_t       e;
    logic [31:0] rnd;
    logic [23:0] m;
    logic [2:0]  rm;
    int          base;

    vecs[0]  = '{24'hFFFFFF, 8'h7E, 1'b0, 1'b1, 1'b0, 3'd0, 24'h800000, 8'h7F, 1'b1, 1'b0, 1'b0};
    vecs[1]  = '{24'hFFFFFF, 8'hFE, 1'b0, 1'b1, 1'b1, 3'd3, 24'h800000, 8'hFF, 1'b1, 1'b1, 1'b0};
    vecs[2]  = '{24'hFFFFFF, 8'hFE, 1'b0, 1'b1, 1'b1, 3'd2, 24'hFFFFFF, 8'hFE, 1'b1, 1'b0, 1'b0};
    vecs[3]  = '{24'h800002, 8'h10, 1'b0, 1'b1, 1'b0, 3'd0, 24'h800002, 8'h10, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{24'h800002, 8'h10, 1'b0, 1'b1, 1'b0, 3'd4, 24'h800003, 8'h10, 1'b1, 1'b0, 1'b0};
    vecs[5]  = '{24'h800002, 8'h10, 1'b0, 1'b1, 1'b0, 3'd1, 24'h800002, 8'h10, 1'b1, 1'b0, 1'b0};
    vecs[6]  = '{24'h800002, 8'h10, 1'b0, 1'b1, 1'b0, 3'd6, 24'h800002, 8'h10, 1'b1, 1'b0, 1'b1};
    vecs[7]  = '{24'h800003, 8'h10, 1'b0, 1'b1, 1'b0, 3'd0, 24'h800004, 8'h10, 1'b1, 1'b0, 1'b0};
    vecs[8]  = '{24'h800000, 8'h10, 1'b1, 1'b0, 1'b1, 3'd2, 24'h800001, 8'h10, 1'b1, 1'b0, 1'b0};
    vecs[9]  = '{24'h800000, 8'h10, 1'b1, 1'b1, 1'b0, 3'd3, 24'h800000, 8'h10, 1'b1, 1'b0, 1'b0};
    vecs[10] = '{24'h800000, 8'h10, 1'b0, 1'b0, 1'b0, 3'd3, 24'h800000, 8'h10, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{24'hFFFFFF, 8'hFF, 1'b0, 1'b1, 1'b0, 3'd3, 24'h800000, 8'hFF, 1'b1, 1'b0, 1'b0};
    vecs[12] = '{24'h800004, 8'h20, 1'b1, 1'b1, 1'b1, 3'd0, 24'h800005, 8'h20, 1'b1, 1'b0, 1'b0};

    tests_run    = 0;
    tests_failed = 0;
    pop_count    = 0;
    tog_run      = 1'b0;
    rst_n        = 1'b0;
    flush        = 1'b0;
    in_valid     = 1'b0;
    out_ready    = 1'b1;
    in_mant      = '0;
    in_exp       = '0;
    in_sign      = 1'b0;
    in_round     = 1'b0;
    in_sticky    = 1'b0;
    in_rm        = '0;
`ifdef ROUNDING_PIPE_TAG_EN
    in_tag       = '0;
`endif

    // Reset state
    #2;
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_out_mant", 32'(out_mant), 32'd0);
    checkOutput("rst_out_exp", 32'(out_exp), 32'd0);
    checkOutput("rst_out_flags", {28'd0, out_sign, out_inexact, out_overflow, out_rm_err}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;

    // Latency: first beat appears exactly two cycles after acceptance
    e = '{vecs[0].x_mant, vecs[0].x_exp, vecs[0].sign, vecs[0].x_inexact,
          vecs[0].x_overflow, vecs[0].x_rm_err, 8'hA5};
    applyStimulus(vecs[0].mant, vecs[0].exp, vecs[0].sign, vecs[0].round, vecs[0].sticky,
                  vecs[0].rm, 8'hA5, e);
    @(negedge clk);
    checkOutput("lat_cycle1_valid", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    checkOutput("lat_cycle2_valid", 32'(out_valid), 32'd1);
    @(posedge clk);
    #1;

    // Vector table, back to back
    for (int i = 0; i < NVEC; i++) begin
      e = '{vecs[i].x_mant, vecs[i].x_exp, vecs[i].sign, vecs[i].x_inexact,
            vecs[i].x_overflow, vecs[i].x_rm_err, 8'(i + 1)};
      applyStimulus(vecs[i].mant, vecs[i].exp, vecs[i].sign, vecs[i].round, vecs[i].sticky,
                    vecs[i].rm, 8'(i + 1), e);
    end
    waitDrain();

    // Eight beats with out_ready cycling 1,0,0,1
    base    = pop_count;
    tog_run = 1'b1;
    fork
      begin
        int c = 0;
        while (tog_run) begin
          out_ready = (c % 4 == 0) || (c % 4 == 3);
          c++;
          @(posedge clk);
          #1;
        end
      end
    join_none
    for (int i = 0; i < 8; i++) begin
      rnd = $urandom;
      m   = (i % 3 == 0) ? 24'hFFFFFF : {1'b1, rnd[22:0]};
      rm  = 3'(i % 6);
      e   = ref_model(m, 8'h40 + 8'(i), rnd[23], rnd[24], rnd[25], rm, 8'(i + 1));
      applyStimulus(m, 8'h40 + 8'(i), rnd[23], rnd[24], rnd[25], rm, 8'(i + 1), e);
    end
    waitDrain();
    tog_run = 1'b0;
    @(posedge clk);
    #1 out_ready = 1'b1;
    checkOutput("b2b_count", 32'(pop_count - base), 32'd8);

    // Flush with two beats held
    out_ready = 1'b0;
    e = ref_model(24'h800010, 8'h30, 1'b0, 1'b1, 1'b1, 3'd3, 8'h11);
    applyStimulus(24'h800010, 8'h30, 1'b0, 1'b1, 1'b1, 3'd3, 8'h11, e);
    e = ref_model(24'h800020, 8'h31, 1'b0, 1'b0, 1'b1, 3'd1, 8'h12);
    applyStimulus(24'h800020, 8'h31, 1'b0, 1'b0, 1'b1, 3'd1, 8'h12, e);
    base      = pop_count;
    flush     = 1'b1;
    in_valid  = 1'b1;
    in_mant   = 24'h800030;
    cur       = ref_model(24'h800030, 8'h32, 1'b0, 1'b0, 1'b0, 3'd0, 8'h13);
    @(negedge clk);
    checkOutput("flush_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    checkOutput("flush_out_valid", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    checkOutput("flush_out_valid2", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    e = ref_model(24'hABCDEF, 8'h55, 1'b1, 1'b1, 1'b0, 3'd4, 8'h14);
    applyStimulus(24'hABCDEF, 8'h55, 1'b1, 1'b1, 1'b0, 3'd4, 8'h14, e);
    @(negedge clk);
    checkOutput("post_flush_lat1", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    checkOutput("post_flush_lat2", 32'(out_valid), 32'd1);
    @(posedge clk);
    #1;
    waitDrain();
    checkOutput("post_flush_count", 32'(pop_count - base), 32'd1);

    // Asynchronous reset with two beats in flight
    out_ready = 1'b0;
    e = ref_model(24'hFFFFFF, 8'h70, 1'b0, 1'b1, 1'b1, 3'd3, 8'h21);
    applyStimulus(24'hFFFFFF, 8'h70, 1'b0, 1'b1, 1'b1, 3'd3, 8'h21, e);
    e = ref_model(24'h812345, 8'h71, 1'b1, 1'b1, 1'b1, 3'd2, 8'h22);
    applyStimulus(24'h812345, 8'h71, 1'b1, 1'b1, 1'b1, 3'd2, 8'h22, e);
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("midrst_out_mant", 32'(out_mant), 32'd0);
    checkOutput("midrst_out_exp", 32'(out_exp), 32'd0);
    checkOutput("midrst_out_flags", {28'd0, out_sign, out_inexact, out_overflow, out_rm_err}, 32'd0);
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    base      = pop_count;
    repeat (5) @(posedge clk);
    #1;
    checkOutput("midrst_no_output", 32'(pop_count - base), 32'd0);
    checkOutput("midrst_out_valid_after", 32'(out_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
